change_dispense_ctrl: RTL and testbench

Sequences the coin hoppers that pay out change after a vending transaction. It accepts a change amount from the transaction FSM and picks denominations greedily (50, 20, 10, 5, 1), using only denominations that are in stock. Each coin is issued to its hopper through a req/ack handshake with a timeout. It also keeps a per-denomination stock count that can be reloaded while the block is idle.

---
 rtl/vend_pkg.sv | 58 +++++
 rtl/denom_picker.sv | 37 +++
 rtl/change_dispense_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared definitions for the change dispenser: denomination
//                indices and coin values, FSM state encoding, fault codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int NUM_DENOM = 5;

    // Denomination indices; bit position in hopper_req and slot in stock.
    localparam logic [2:0] DENOM_1  = 3'd0;
    localparam logic [2:0] DENOM_5  = 3'd1;
    localparam logic [2:0] DENOM_10 = 3'd2;
    localparam logic [2:0] DENOM_20 = 3'd3;
    localparam logic [2:0] DENOM_50 = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_REQ    = 3'd2,
        S_REL    = 3'd3,
        S_DONE   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NO_COIN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    // Coin value for a denomination index.
    function automatic logic [7:0] denom_value(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            DENOM_1:  val = 8'd1;
            DENOM_5:  val = 8'd5;
            DENOM_10: val = 8'd10;
            DENOM_20: val = 8'd20;
            DENOM_50: val = 8'd50;
            default:  val = 8'd0;
        endcase
        return val;
    endfunction

    // Index of the set bit in a one-hot denomination vector.
    function automatic logic [2:0] onehot_to_idx(input logic [NUM_DENOM-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int d = 0; d < NUM_DENOM; d++) begin
            if (oh[d]) idx = 3'(d);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/denom_picker.sv
`default_nettype none
// ============================================================================
//  Module      : denom_picker
//  Description : Combinational greedy coin selector. Chooses the largest
//                denomination whose value fits in the amount still owed and
//                whose hopper is not empty.
//  Ports       : remaining [7:0] - amount still owed
//                in_stock  [4:0] - per-denomination "stock non-zero" flags
//                choice    [4:0] - one-hot selected denomination
//                valid           - a denomination was found
//  Revision    : 1.0 - initial release
// ============================================================================
module denom_picker
    import vend_pkg::*;
(
    input  logic [7:0]           remaining,
    input  logic [NUM_DENOM-1:0] in_stock,
    output logic [NUM_DENOM-1:0] choice,
    output logic                 valid
);

    always_comb begin
        logic found;
        found  = 1'b0;
        choice = '0;
        // Scan from the largest coin downwards; first fit wins.
        for (int d = NUM_DENOM - 1; d >= 0; d--) begin
            if (!found && in_stock[d] && (denom_value(3'(d)) <= remaining)) begin
                choice[d] = 1'b1;
                found     = 1'b1;
            end
        end
        valid = found;
    end

endmodule
`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispense_ctrl
//  Description : Pays out change through five coin hoppers. Picks coins
//                greedily (50/20/10/5/1) among denominations in stock, issues
//                each coin over a req/ack handshake guarded by a timeout and
//                tracks per-denomination stock, reloadable while idle.
//  Ports       : clk, rst (async, active-high)
//                start, change_amt[7:0], abort      - payout control
//                hopper_req[4:0], hopper_ack        - hopper handshake
//                load_en, load_sel[2:0], load_cnt   - stock reload (idle only)
//                stock[5*STOCK_W-1:0]               - packed stock counters
//                remaining[7:0], busy, done, fail, err[1:0] - status
//                low_stock[4:0]                     - only with STOCK_LOW_WARN_EN
//  Options     : `define STOCK_LOW_WARN_EN adds the low_stock output.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int STOCK_W     = 6,
    parameter int INIT_STOCK  = 10,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [7:0]                     change_amt,
    input  logic                           abort,
    output logic [NUM_DENOM-1:0]           hopper_req,
    input  logic                           hopper_ack,
    input  logic                           load_en,
    input  logic [2:0]                     load_sel,
    input  logic [STOCK_W-1:0]             load_cnt,
    output logic [NUM_DENOM*STOCK_W-1:0]   stock,
`ifdef STOCK_LOW_WARN_EN
    output logic [NUM_DENOM-1:0]           low_stock,
`endif
    output logic [7:0]                     remaining,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [1:0]                     err
);

    localparam int                 TMR_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);

    state_t               state;
    logic [STOCK_W-1:0]   stock_cnt [NUM_DENOM];
    logic [TMR_W-1:0]     timer;
    logic [2:0]           sel_idx;
    logic                 abort_lat;

    logic [NUM_DENOM-1:0] stock_nz;
    logic [NUM_DENOM-1:0] pick_choice;
    logic                 pick_valid;

    for (genvar d = 0; d < NUM_DENOM; d++) begin : g_stock
        assign stock[d*STOCK_W +: STOCK_W] = stock_cnt[d];
        assign stock_nz[d]                 = |stock_cnt[d];
    end

    assign busy = (state != S_IDLE);

    denom_picker u_picker (
        .remaining (remaining),
        .in_stock  (stock_nz),
        .choice    (pick_choice),
        .valid     (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= 8'd0;
            hopper_req <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            err        <= ERR_NONE;
            abort_lat  <= 1'b0;
            timer      <= '0;
            sel_idx    <= 3'd0;
            for (int d = 0; d < NUM_DENOM; d++) begin
                stock_cnt[d] <= STOCK_RST;
            end
        end else begin
            done <= 1'b0;
            fail <= 1'b0;

            // Sticky abort: acted upon only at the next coin boundary.
            if (state != S_IDLE) begin
                abort_lat <= abort_lat | abort;
            end

            case (state)
                S_IDLE: begin
                    // A reload in the same cycle as start lands before the
                    // first SELECT, so selection sees the new count.
                    if (load_en) begin
                        for (int d = 0; d < NUM_DENOM; d++) begin
                            if (load_sel == 3'(d)) stock_cnt[d] <= load_cnt;
                        end
                    end
                    if (start) begin
                        state     <= S_SELECT;
                        remaining <= change_amt;
                        err       <= ERR_NONE;
                        abort_lat <= 1'b0;
                    end
                end

                S_SELECT: begin
                    if (abort_lat) begin
                        state <= S_FAIL;
                        err   <= ERR_ABORT;
                        fail  <= 1'b1;
                    end else if (remaining == 8'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (pick_valid) begin
                        state      <= S_REQ;
                        hopper_req <= pick_choice;
                        sel_idx    <= onehot_to_idx(pick_choice);
                        timer      <= '0;
                    end else begin
                        state <= S_FAIL;
                        err   <= ERR_NO_COIN;
                        fail  <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (hopper_ack) begin
                        state      <= S_REL;
                        hopper_req <= '0;
                        timer      <= '0;
                        remaining  <= remaining - denom_value(sel_idx);
                        for (int d = 0; d < NUM_DENOM; d++) begin
                            if ((sel_idx == 3'(d)) && (stock_cnt[d] != '0)) begin
                                stock_cnt[d] <= stock_cnt[d] - STOCK_W'(1);
                            end
                        end
                    end else if (timer == TMR_LAST) begin
                        state      <= S_FAIL;
                        hopper_req <= '0;
                        err        <= ERR_TIMEOUT;
                        fail       <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_REL: begin
                    // Wait for the hopper to release ack before the next coin.
                    if (!hopper_ack) begin
                        state <= S_SELECT;
                    end else if (timer == TMR_LAST) begin
                        state <= S_FAIL;
                        err   <= ERR_TIMEOUT;
                        fail  <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_DONE:  state <= S_IDLE;
                S_FAIL:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STOCK_LOW_WARN_EN
    localparam logic [STOCK_W-1:0] LOW_LIMIT = STOCK_W'(3);

    for (genvar d = 0; d < NUM_DENOM; d++) begin : g_low_stock
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                low_stock[d] <= (STOCK_RST < LOW_LIMIT);
            end else begin
                low_stock[d] <= (stock_cnt[d] < LOW_LIMIT);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispense_ctrl
//  Description : Self-checking bench for change_dispense_ctrl. A behavioural
//                greedy-payout model predicts coin sequences, outcomes and
//                stock; a hopper responder answers requests with random delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispense_ctrl;

    localparam int SW  = 6;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    change_amt = 8'd0;
    logic          abort = 1'b0;
    logic [4:0]    hopper_req;
    logic          hopper_ack = 1'b0;
    logic          load_en = 1'b0;
    logic [2:0]    load_sel = 3'd0;
    logic [SW-1:0] load_cnt = '0;
    logic [5*SW-1:0] stock;
    logic [7:0]    remaining;
    logic          busy, done, fail;
    logic [1:0]    err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    change_dispense_ctrl #(
        .STOCK_W     (SW),
        .INIT_STOCK  (10),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .change_amt (change_amt),
        .abort      (abort),
        .hopper_req (hopper_req),
        .hopper_ack (hopper_ack),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .load_cnt   (load_cnt),
        .stock      (stock),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .err        (err)
    );

    // ---------------- reference model ----------------
    int         VAL [5] = '{1, 5, 10, 20, 50};
    int         model_stock [5];
    logic [4:0] exp_reqs [$];
    bit         exp_done;
    int         exp_err;
    int         exp_rem;

    // Observations from the most recent payout
    logic [4:0] obs_reqs [$];
    bit         obs_done, obs_fail;
    logic [1:0] obs_err;
    logic [7:0] obs_rem;

    function automatic int dut_stock(input int d);
        return int'(stock[d*SW +: SW]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 5; d++) model_stock[d] = 10;
    endtask

    // Greedy payout from the rules: biggest coin that fits and is stocked.
    task automatic model_payout(input int amt, input int abort_at,
                                input bit ld, input int ld_sel, input int ld_cnt);
        int rem, pick;
        bit aborted;
        if (ld && ld_sel < 5) model_stock[ld_sel] = ld_cnt;
        exp_reqs.delete();
        rem = amt;
        aborted = 0;
        forever begin
            if (aborted) begin exp_done = 0; exp_err = 3; break; end
            if (rem == 0) begin exp_done = 1; exp_err = 0; break; end
            pick = -1;
            for (int d = 4; d >= 0; d--) begin
                if (pick < 0 && VAL[d] <= rem && model_stock[d] > 0) pick = d;
            end
            if (pick < 0) begin exp_done = 0; exp_err = 1; break; end
            exp_reqs.push_back(5'(1 << pick));
            rem -= VAL[pick];
            model_stock[pick] -= 1;
            if (exp_reqs.size() - 1 == abort_at) aborted = 1;
        end
        exp_rem = rem;
    endtask

    task automatic do_load(input int sel, input int cnt);
        @(negedge clk);
        load_en = 1'b1; load_sel = 3'(sel); load_cnt = SW'(cnt);
        @(negedge clk);
        load_en = 1'b0;
        if (sel < 5) model_stock[sel] = cnt;
    endtask

    // Drives one payout and acts as the hopper; records what the DUT did.
    task automatic run_payout(input logic [7:0] amt, input int abort_at, input bit busy_load,
                              input bit ld, input int ld_sel, input int ld_cnt);
        int  cycles, w;
        bit  finished;
        obs_reqs.delete();
        obs_done = 0; obs_fail = 0; obs_err = 2'b00; obs_rem = 8'd0;
        @(negedge clk);
        start = 1'b1; change_amt = amt;
        load_en = ld; load_sel = 3'(ld_sel); load_cnt = SW'(ld_cnt);
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        cycles = 0; finished = 0;
        while (!finished && cycles < 5000) begin
            if (done || fail) begin
                obs_done = done; obs_fail = fail; obs_err = err; obs_rem = remaining;
                finished = 1;
            end else if (hopper_req != 5'd0) begin
                obs_reqs.push_back(hopper_req);
                if (int'(obs_reqs.size()) - 1 == abort_at) abort = 1'b1;
                if (busy_load) begin load_en = 1'b1; load_sel = 3'd0; load_cnt = '0; end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                hopper_ack = 1'b1;
                w = 0;
                do begin @(negedge clk); w++; end while (hopper_req != 5'd0 && w < 100);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                hopper_ack = 1'b0;
                @(negedge clk);
                cycles += 10;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        abort = 1'b0; load_en = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL payout_end: no done/fail pulse seen within budget (amt=%0d)", amt);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (hopper_req !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b busy=%b done=%b fail=%b, want 0", hopper_req, busy, done, fail);
        end
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if (remaining !== 8'd0 || err !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: remaining=%0d err=%b, want 0/00", remaining, err);
        end
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (dut_stock(d) !== 10) begin
                errors++;
                $display("FAIL reset_stock[%0d]: got %0d want 10", d, dut_stock(d));
            end
        end
    endtask

    task automatic test_full_37();
        model_payout(37, -1, 0, 0, 0);
        run_payout(8'd37, -1, 0, 0, 0, 0);
        checks++;
        if (obs_done !== 1'b1 || obs_rem !== 8'd0) begin
            errors++;
            $display("FAIL full37_done: done=%b rem=%0d, want 1/0", obs_done, obs_rem);
        end
        checks++;
        if (obs_reqs.size() != exp_reqs.size()) begin
            errors++;
            $display("FAIL full37_count: got %0d coins want %0d", obs_reqs.size(), exp_reqs.size());
        end else begin
            for (int i = 0; i < obs_reqs.size(); i++) begin
                checks++;
                if (obs_reqs[i] !== exp_reqs[i]) begin
                    errors++;
                    $display("FAIL full37_req[%0d]: got %b want %b", i, obs_reqs[i], exp_reqs[i]);
                end
            end
        end
        checks++;
        if (dut_stock(4) !== 10 || dut_stock(3) !== 9 || dut_stock(2) !== 9 ||
            dut_stock(1) !== 9 || dut_stock(0) !== 8) begin
            errors++;
            $display("FAIL full37_stock: got %0d %0d %0d %0d %0d want 10 9 9 9 8",
                     dut_stock(4), dut_stock(3), dut_stock(2), dut_stock(1), dut_stock(0));
        end
    endtask

    task automatic test_no_five();
        do_load(1, 0);
        model_payout(37, -1, 0, 0, 0);
        run_payout(8'd37, -1, 0, 0, 0, 0);
        checks++;
        if (obs_done !== 1'b1 || obs_rem !== 8'd0 || obs_reqs.size() != 9) begin
            errors++;
            $display("FAIL no5_result: done=%b rem=%0d coins=%0d, want 1/0/9", obs_done, obs_rem, obs_reqs.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (obs_reqs[i] !== exp_reqs[i]) begin
                    errors++;
                    $display("FAIL no5_req[%0d]: got %b want %b", i, obs_reqs[i], exp_reqs[i]);
                end
            end
        end
        checks++;
        if (dut_stock(0) !== model_stock[0] || dut_stock(1) !== 0) begin
            errors++;
            $display("FAIL no5_stock: s1=%0d s5=%0d want %0d/0", dut_stock(0), dut_stock(1), model_stock[0]);
        end
    endtask

    task automatic test_only_ones();
        for (int d = 1; d < 5; d++) do_load(d, 0);
        do_load(0, 2);
        model_payout(3, -1, 0, 0, 0);
        run_payout(8'd3, -1, 0, 0, 0, 0);
        checks++;
        if (obs_fail !== 1'b1 || obs_err !== 2'b01 || obs_rem !== 8'd1 || obs_reqs.size() != 2) begin
            errors++;
            $display("FAIL nocoin: fail=%b err=%b rem=%0d coins=%0d, want 1/01/1/2",
                     obs_fail, obs_err, obs_rem, obs_reqs.size());
        end
        checks++;
        if (dut_stock(0) !== 0) begin
            errors++;
            $display("FAIL nocoin_stock: got %0d want 0", dut_stock(0));
        end
    endtask

    task automatic test_timeout();
        int n, guard;
        for (int d = 0; d < 5; d++) do_load(d, 10);
        @(negedge clk);
        start = 1'b1; change_amt = 8'd7;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (hopper_req == 5'd0 && guard < 10) begin @(negedge clk); guard++; end
        n = 0;
        while (hopper_req != 5'd0 && n < 4 * TMO) begin n++; @(negedge clk); end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_len: req held %0d cycles want %0d", n, TMO);
        end
        checks++;
        if (fail !== 1'b1 || err !== 2'b10 || remaining !== 8'd7) begin
            errors++;
            $display("FAIL timeout_status: fail=%b err=%b rem=%0d, want 1/10/7", fail, err, remaining);
        end
        @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (dut_stock(d) !== model_stock[d]) begin
                errors++;
                $display("FAIL timeout_stock[%0d]: got %0d want %0d", d, dut_stock(d), model_stock[d]);
            end
        end
    endtask

    task automatic test_abort();
        model_payout(25, 0, 0, 0, 0);
        run_payout(8'd25, 0, 1, 0, 0, 0);
        checks++;
        if (obs_fail !== 1'b1 || obs_err !== 2'b11 || obs_rem !== 8'd5 || obs_reqs.size() != 1) begin
            errors++;
            $display("FAIL abort: fail=%b err=%b rem=%0d coins=%0d, want 1/11/5/1",
                     obs_fail, obs_err, obs_rem, obs_reqs.size());
        end
        checks++;
        if (dut_stock(0) !== 10 || dut_stock(3) !== 9) begin
            errors++;
            $display("FAIL abort_stock: s1=%0d s20=%0d want 10/9", dut_stock(0), dut_stock(3));
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        @(negedge clk);
        start = 1'b1; change_amt = 8'd5;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (hopper_req == 5'd0 && guard < 10) begin @(negedge clk); guard++; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (hopper_req !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: req=%b busy=%b want 0/0", hopper_req, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (dut_stock(d) !== 10) begin
                errors++;
                $display("FAIL rstmid_stock[%0d]: got %0d want 10", d, dut_stock(d));
            end
        end
        start = 1'b1; change_amt = 8'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || hopper_req !== 5'd0) begin
            errors++;
            $display("FAIL zero_early: done=%b req=%b want 0/0", done, hopper_req);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || hopper_req !== 5'd0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL zero_done: done=%b req=%b rem=%0d want 1/0/0", done, hopper_req, remaining);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int amt, abort_at, sel, cnt;
        bit ld, bl;
        for (int it = 0; it < 30; it++) begin
            amt      = $urandom_range(0, 120);
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            ld       = ($urandom_range(0, 2) == 0);
            sel      = $urandom_range(0, 7);
            cnt      = $urandom_range(0, 63);
            bl       = ($urandom_range(0, 3) == 0);
            model_payout(amt, abort_at, ld, sel, cnt);
            run_payout(8'(amt), abort_at, bl, ld, sel, cnt);
            checks++;
            if (obs_done !== exp_done || obs_fail === exp_done ||
                obs_err !== 2'(exp_err) || obs_rem !== 8'(exp_rem)) begin
                errors++;
                $display("FAIL rand%0d_outcome: done=%b err=%b rem=%0d want done=%b err=%0d rem=%0d",
                         it, obs_done, obs_err, obs_rem, exp_done, exp_err, exp_rem);
            end
            checks++;
            if (obs_reqs.size() != exp_reqs.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d coins want %0d", it, obs_reqs.size(), exp_reqs.size());
            end else begin
                for (int i = 0; i < obs_reqs.size(); i++) begin
                    checks++;
                    if (obs_reqs[i] !== exp_reqs[i]) begin
                        errors++;
                        $display("FAIL rand%0d_req[%0d]: got %b want %b", it, i, obs_reqs[i], exp_reqs[i]);
                    end
                end
            end
            @(negedge clk);
            for (int d = 0; d < 5; d++) begin
                checks++;
                if (dut_stock(d) !== model_stock[d]) begin
                    errors++;
                    $display("FAIL rand%0d_stock[%0d]: got %0d want %0d", it, d, dut_stock(d), model_stock[d]);
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_37();
        test_no_five();
        test_only_ones();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
